instruction_encoder: RTL and testbench
======================================

INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 2, output FIFO entries (power of two, >=2).
REQ-002 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  request valid.
REQ-005 SHALL have port in_ready  output  1  request accepted when in_valid and in_ready are both 1.
REQ-006 SHALL have ports in_opcode input 7, in_rd input 5, in_rs1 input 5, in_rs2 input 5, in_funct3 input 3, in_funct7 input 7: instruction fields.
REQ-007 SHALL have port in_imm  input  32  signed byte-offset/immediate value.
REQ-008 SHALL have ports out_valid output 1, out_ready input 1: output handshake.
REQ-009 SHALL have port out_inst  output  32  encoded RV32 instruction at FIFO head.
REQ-010 SHALL have port out_err  output  1  head entry immediate not representable.
REQ-011 SHALL have ports emit_count output 16 (instructions delivered) and err_seen output 1 (sticky error).

Function
REQ-012 SHALL select format from in_opcode:
- I: 0000011, 0000111, 0010011, 1100111.
- S: 0100011, 0100111.
- B: 1100011.
- U: 0010111, 0110111.
- J: 1101111.
- R: all other opcodes.
REQ-013 SHALL always place opcode in [6:0]; rd in [11:7] for R/I/U/J; funct3 in [14:12] for R/I/S/B; rs1 in [19:15] for R/I/S/B; rs2 in [24:20] for R/S/B; funct7 in [31:25] for R only.
REQ-014 SHALL pack immediates:
- I: [31:20]=imm[11:0].
- S: [31:25]=imm[11:5], [11:7]=imm[4:0].
- B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
- U: [31:12]=imm[31:12].
- J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
REQ-015 SHALL ignore in_imm for R-type; unused field bits are dropped silently.
REQ-016 SHALL store each accepted request as one FIFO entry {inst, err} at the accepting edge; out_valid SHALL rise on the following cycle (latency 1), with no combinational in->out path.
REQ-017 SHALL drive in_ready = (occupancy < DEPTH), registered-state only; when full, no push SHALL occur even if a pop happens in the same cycle.
REQ-018 SHALL, on a simultaneous push and pop when not full, leave occupancy unchanged and preserve FIFO order.
REQ-019 SHALL hold out_inst/out_err stable while out_valid=1 and out_ready=0.
REQ-020 SHALL drive out_inst=0 and out_err=0 when empty.
REQ-021 SHALL wrap read/write pointers modulo DEPTH.
REQ-022 SHALL increment emit_count on each out_valid & out_ready, wrapping 0xFFFF->0x0000.
REQ-023 SHALL set err_seen when an entry with err=1 is pushed; cleared only by reset.

Reset
REQ-024 SHALL, on reset assertion (asynchronously, including mid-transfer), empty the FIFO and drive out_valid=0, out_inst=0, out_err=0, emit_count=0, err_seen=0, in_ready=1.
REQ-025 SHALL accept a request on the first rising edge after reset deasserts.

Configuration
REQ-026 SHALL, when macro RVSIMPLE_IMM_RANGE_CHECK_EN is defined, flag err=1 if in_imm is unrepresentable; the instruction is still encoded truncated per REQ-014:
- I/S: imm[31:11] not all equal.
- B: imm[31:12] not all equal, or imm[0]=1.
- J: imm[31:20] not all equal, or imm[0]=1.
- U: imm[11:0] != 0.
REQ-027 SHALL, when RVSIMPLE_IMM_RANGE_CHECK_EN is undefined, have no check logic and tie out_err and err_seen to 0.

Verification
REQ-028 SHALL cover: opcode 0010011, rd=1, rs1=0, funct3=0, imm=0xFFFFFFFF -> out_inst=0xFFF00093, out_err=0, out_valid one cycle after accept.
REQ-029 SHALL cover: opcode 1100011, rs1=1, rs2=2, funct3=0, imm=8 -> out_inst=0x00208463.
REQ-030 SHALL cover: opcode 0110111, rd=5, imm=0x12345000 -> out_inst=0x123452B7, out_err=0.
REQ-031 SHALL cover: opcode 1101111, rd=0, imm=3 with check enabled -> out_inst=0x0020006F, out_err=1, err_seen=1; with check disabled -> same inst, out_err=0, err_seen=0.
REQ-032 SHALL cover: out_ready=0, three requests offered -> in_ready=0 after two accepts; release out_ready -> instructions emerge in order, emit_count=3.
REQ-033 SHALL cover: reset asserted with two entries queued -> same cycle out_valid=0, in_ready=1, emit_count=0, err_seen=0.

Source files
------------

// File: rtl/instruction_encoder.sv
// RV32 instruction encoder: packs instruction fields into a 32-bit word and queues it in a DEPTH-entry FIFO.
// Optional immediate range checking is enabled by defining RVSIMPLE_IMM_RANGE_CHECK_EN.
module instruction_encoder #(
  parameter int DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_err,
  output logic [15:0] emit_count,
  output logic        err_seen
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;

  fmt_e        fmt;
  logic [31:0] enc_inst;
  logic        enc_err;
  logic        push;
  logic        pop;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [31:0]   inst_mem [DEPTH];

  // NOTE: every signal assigned in always_comb gets a default first so no path can infer a latch.
  always_comb begin
    fmt = FMT_R;
    case (in_opcode)
      7'b0000011, 7'b0000111, 7'b0010011, 7'b1100111: fmt = FMT_I;
      7'b0100011, 7'b0100111:                         fmt = FMT_S;
      7'b1100011:                                     fmt = FMT_B;
      7'b0010111, 7'b0110111:                         fmt = FMT_U;
      7'b1101111:                                     fmt = FMT_J;
      default:                                        fmt = FMT_R;
    endcase
  end

  always_comb begin
    enc_inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
    case (fmt)
      FMT_I: enc_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      FMT_S: enc_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      FMT_B: enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                         in_imm[4:1], in_imm[11], in_opcode};
      FMT_U: enc_inst = {in_imm[31:12], in_rd, in_opcode};
      FMT_J: enc_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
      default: enc_inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
    endcase
  end

`ifdef RVSIMPLE_IMM_RANGE_CHECK_EN
  // Upper bits must be a pure sign extension of the highest encodable bit.
  always_comb begin
    enc_err = 1'b0;
    case (fmt)
      FMT_I, FMT_S: enc_err = !(&in_imm[31:11] || ~|in_imm[31:11]);
      FMT_B:        enc_err = !(&in_imm[31:12] || ~|in_imm[31:12]) || in_imm[0];
      FMT_J:        enc_err = !(&in_imm[31:20] || ~|in_imm[31:20]) || in_imm[0];
      FMT_U:        enc_err = |in_imm[11:0];
      default:      enc_err = 1'b0;
    endcase
  end
`else
  assign enc_err = 1'b0;
`endif

  assign in_ready  = (count < CNT_MAX);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // NOTE: storage is deliberately not reset; the head is gated by occupancy so stale words never escape.
  always_ff @(posedge clock) begin
    if (push) inst_mem[wr_ptr] <= enc_inst;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      emit_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (pop) emit_count <= emit_count + 16'd1;
    end
  end

  assign out_inst = out_valid ? inst_mem[rd_ptr] : 32'd0;

`ifdef RVSIMPLE_IMM_RANGE_CHECK_EN
  logic err_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (push) err_mem[wr_ptr] <= enc_err;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                err_seen <= 1'b0;
    else if (push && enc_err) err_seen <= 1'b1;
  end

  assign out_err = out_valid ? err_mem[rd_ptr] : 1'b0;
`else
  assign out_err  = 1'b0;
  assign err_seen = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_encoder.sv
// Self-checking bench for instruction_encoder: arithmetic reference model with a per-cycle compare,
// plus directed literal expectations. Honours RVSIMPLE_IMM_RANGE_CHECK_EN like the design.
module tb_instruction_encoder;

  localparam int DEPTH = 2;

`ifdef RVSIMPLE_IMM_RANGE_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;
  logic [15:0] emit_count;
  logic        err_seen;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  instruction_encoder #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_err(out_err),
    .emit_count(emit_count), .err_seen(err_seen)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder built from shift/mask arithmetic and signed range tests.
  function automatic logic [32:0] model_enc(input logic [6:0] op, input logic [4:0] rd,
                                            input logic [4:0] rs1, input logic [4:0] rs2,
                                            input logic [2:0] f3, input logic [6:0] f7,
                                            input logic [31:0] imm);
    int unsigned u;
    int          s;
    int unsigned w;
    bit          e;
    u = imm;
    s = imm;
    w = 0;
    e = 0;
    case (op)
      7'b0000011, 7'b0000111, 7'b0010011, 7'b1100111: begin
        w = ((u & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'(op);
        e = (s < -2048) || (s > 2047);
      end
      7'b0100011, 7'b0100111: begin
        w = (((u >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) |
            (32'(f3) << 12) | ((u & 32'h1F) << 7) | 32'(op);
        e = (s < -2048) || (s > 2047);
      end
      7'b1100011: begin
        w = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (32'(rs2) << 20) |
            (32'(rs1) << 15) | (32'(f3) << 12) | (((u >> 1) & 32'hF) << 8) |
            (((u >> 11) & 1) << 7) | 32'(op);
        e = (s < -4096) || (s > 4095) || (u % 2 != 0);
      end
      7'b0010111, 7'b0110111: begin
        w = (u & 32'hFFFFF000) | (32'(rd) << 7) | 32'(op);
        e = (u % 4096) != 0;
      end
      7'b1101111: begin
        w = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21) | (((u >> 11) & 1) << 20) |
            (((u >> 12) & 32'hFF) << 12) | (32'(rd) << 7) | 32'(op);
        e = (s < -1048576) || (s > 1048575) || (u % 2 != 0);
      end
      default: begin
        w = (32'(f7) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) |
            (32'(rd) << 7) | 32'(op);
        e = 0;
      end
    endcase
    return {w, e && CHK_EN};
  endfunction

  logic [32:0] q[$];
  int unsigned emit_m;
  bit          err_seen_m;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      q.delete();
      emit_m     = 0;
      err_seen_m = 0;
    end else begin
      bit          do_push;
      bit          do_pop;
      logic [32:0] ent;
      do_push = (in_valid === 1'b1) && (q.size() < DEPTH);
      do_pop  = (out_ready === 1'b1) && (q.size() > 0);
      if (do_pop) begin
        void'(q.pop_front());
        emit_m = (emit_m + 1) % 65536;
      end
      if (do_push) begin
        ent = model_enc(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
        q.push_back(ent);
        if (ent[0]) err_seen_m = 1;
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      check("in_ready",   32'(in_ready),   32'(q.size() < DEPTH));
      check("out_valid",  32'(out_valid),  32'(q.size() != 0));
      check("out_inst",   out_inst,        (q.size() != 0) ? q[0][32:1] : 32'd0);
      check("out_err",    32'(out_err),    (q.size() != 0) ? 32'(q[0][0]) : 32'd0);
      check("emit_count", 32'(emit_count), emit_m);
      check("err_seen",   32'(err_seen),   32'(err_seen_m));
    end
  end

  task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] imm);
    bit done;
    done      = 0;
    in_opcode = op;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_funct7 = f7;
    in_imm    = imm;
    in_valid  = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      if (in_ready === 1'b1) done = 1;
      @(posedge clock);
      #1;
    end
    check("send_accepted", 32'(done), 32'd1);
    @(negedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit empty;
    empty     = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && !empty; i++) begin
      @(negedge clock);
      #1;
      if (out_valid === 1'b0) empty = 1;
    end
    check("drain_empty", 32'(empty), 32'd1);
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_opcode = '0;
    in_rd     = '0;
    in_rs1    = '0;
    in_rs2    = '0;
    in_funct3 = '0;
    in_funct7 = '0;
    in_imm    = '0;
    #1;
    cmp_en = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    check("rst_out_valid",  32'(out_valid),  32'd0);
    check("rst_in_ready",   32'(in_ready),   32'd1);
    check("rst_out_inst",   out_inst,        32'd0);
    check("rst_emit_count", 32'(emit_count), 32'd0);
    reset = 1'b0;

    // addi x1, x0, -1 accepted on the first edge after reset release
    send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF);
    check("addi_valid", 32'(out_valid), 32'd1);
    check("addi_inst",  out_inst,       32'hFFF00093);
    check("addi_err",   32'(out_err),   32'd0);
    drain();

    send(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
    check("beq_inst", out_inst, 32'h00208463);
    drain();

    send(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
    check("lui_inst", out_inst,     32'h123452B7);
    check("lui_err",  32'(out_err), 32'd0);
    drain();

    send(7'b1101111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    check("jal_inst",     out_inst,         32'h0020006F);
    check("jal_err",      32'(out_err),     32'(CHK_EN));
    check("jal_err_seen", 32'(err_seen),    32'(CHK_EN));
    drain();

    send(7'b0100011, 5'd0, 5'd2, 5'd3, 3'd2, 7'd0, 32'hFFFFFFFC);
    check("sw_inst", out_inst, 32'hFE312E23);
    drain();

    // R-type ignores the immediate entirely
    send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEADBEEF);
    check("add_inst", out_inst, 32'h002081B3);
    drain();

    // Backpressure: three offers against a two-entry queue
    do_reset();
    fork
      begin
        send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        send(7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
        send(7'b0010011, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
      end
      begin
        repeat (3) @(negedge clock);
        #1;
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_head",     out_inst,      32'h00100093);
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_emit_count", 32'(emit_count), 32'd3);

    // Asynchronous reset with two entries queued
    send(7'b1101111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    send(7'b0010011, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4);
    check("pre_rst_valid",    32'(out_valid), 32'd1);
    check("pre_rst_in_ready", 32'(in_ready),  32'd0);
    check("pre_rst_err_seen", 32'(err_seen),  32'(CHK_EN));
    #2;
    reset = 1'b1;
    #1;
    check("arst_out_valid",  32'(out_valid),  32'd0);
    check("arst_in_ready",   32'(in_ready),   32'd1);
    check("arst_out_inst",   out_inst,        32'd0);
    check("arst_out_err",    32'(out_err),    32'd0);
    check("arst_emit_count", 32'(emit_count), 32'd0);
    check("arst_err_seen",   32'(err_seen),   32'd0);
    @(negedge clock);
    #1;
    reset = 1'b0;

    // Continuous streaming long enough to wrap emit_count
    in_opcode = 7'b0110011;
    in_rd     = 5'd7;
    in_rs1    = 5'd8;
    in_rs2    = 5'd9;
    in_funct3 = 3'd7;
    in_funct7 = 7'h20;
    in_imm    = 32'd0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    repeat (65540) @(negedge clock);
    #1;
    in_valid = 1'b0;
    drain();
    check("wrap_emit_count", 32'(emit_count), emit_m);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
